// File: rtl/mux2_arb_ctrl.sv
// rtl/mux2_arb_ctrl.sv - two-requester burst arbiter with break-before-make guard and registered output mux
// Optional MUX2_ARB_INV_EN: registered output carries ~D[S] instead of D[S].
module mux2_arb_ctrl #(
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 4
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             LAST0,
  input  logic             LAST1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             YV
);

  typedef enum logic [1:0] {IDLE, GUARD, BUSY} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       ptr;

  logic             req_s;
  logic             req_o;
  logic             last_s;
  logic             gnt_s;
  logic [WIDTH-1:0] d_s;
  logic [WIDTH-1:0] y_nxt;
  logic [3:0]       cnt_nxt;
  logic             xfer;
  logic             last_beat;

  always_comb begin
    req_s     = S ? REQ1 : REQ0;
    req_o     = S ? REQ0 : REQ1;
    last_s    = S ? LAST1 : LAST0;
    gnt_s     = S ? GNT1 : GNT0;
    d_s       = S ? D1 : D0;
    cnt_nxt   = cnt + 4'd1;
    xfer      = (state == BUSY) && gnt_s && req_s;
    last_beat = xfer && (last_s || (cnt_nxt == 4'(MAXBURST)));
`ifdef MUX2_ARB_INV_EN
    y_nxt     = ~d_s;
`else
    y_nxt     = d_s;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      state <= IDLE;
      S     <= 1'b0;
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      Y     <= '0;
      YV    <= 1'b0;
      cnt   <= 4'd0;
      ptr   <= 1'b1;
    end else begin
      YV <= xfer;
      if (xfer) begin
        Y   <= y_nxt;
        cnt <= cnt_nxt;
        ptr <= S;
      end
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            // Under contention the requester not granted last time wins.
            S     <= (REQ0 && REQ1) ? ~ptr : REQ1;
            cnt   <= 4'd0;
            state <= GUARD;
          end
        end
        GUARD: begin
          state <= BUSY;
          if (S) GNT1 <= 1'b1;
          else   GNT0 <= 1'b1;
        end
        BUSY: begin
          if (!req_s || last_beat) begin
            GNT0 <= 1'b0;
            GNT1 <= 1'b0;
            if (req_o) begin
              S     <= ~S;
              cnt   <= 4'd0;
              state <= GUARD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_arb_ctrl.sv
// tb/tb_mux2_arb_ctrl.sv - directed self-checking bench for mux2_arb_ctrl
module tb_mux2_arb_ctrl;
  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             R = 1'b0;
  logic             REQ0 = 1'b0, REQ1 = 1'b0, LAST0 = 1'b0, LAST1 = 1'b0;
  logic [WIDTH-1:0] D0 = '0, D1 = '0;
  logic             GNT0, GNT1, S, YV;
  logic [WIDTH-1:0] Y;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_s  = 1'b0;

  mux2_arb_ctrl #(.WIDTH(WIDTH), .MAXBURST(4)) dut (
    .CLK(CLK), .R(R), .REQ0(REQ0), .REQ1(REQ1), .LAST0(LAST0), .LAST1(LAST1),
    .D0(D0), .D1(D1), .GNT0(GNT0), .GNT1(GNT1), .S(S), .Y(Y), .YV(YV)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xf(input logic [7:0] d);
`ifdef MUX2_ARB_INV_EN
    return ~d;
`else
    return d;
`endif
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    R = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; LAST0 = 1'b0; LAST1 = 1'b0;
    step;
    R = 1'b1;
  endtask

  // Grants exclusive and select stable during ownership.
  always @(negedge CLK) begin
    check("gnt_onehot", 32'(GNT0 & GNT1), 32'd0);
    check("s_stable", 32'(((GNT0 | GNT1) === 1'b1) && (S !== prev_s)), 32'd0);
    prev_s = S;
  end

  initial begin
    // Reset with both requesting
    R = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1;
    step; step;
    check("rst_gnt0", 32'(GNT0), 0);
    check("rst_gnt1", 32'(GNT1), 0);
    check("rst_s", 32'(S), 0);
    check("rst_y", 32'(Y), 0);
    check("rst_yv", 32'(YV), 0);
    R = 1'b1;
    step;
    check("rst_e1_gnt0", 32'(GNT0), 0);
    check("rst_e1_s", 32'(S), 0);
    step;
    check("rst_e2_gnt0", 32'(GNT0), 1);
    check("rst_e2_gnt1", 32'(GNT1), 0);
    REQ0 = 1'b0; REQ1 = 1'b0;
    step;
    check("rst_e3_gnt0", 32'(GNT0), 0);
    check("rst_e3_yv", 32'(YV), 0);

    // Single requester, LAST on first beat
    do_reset;
    REQ0 = 1'b1; D0 = 8'h5A; LAST0 = 1'b1;
    step;
    check("single_e1_s", 32'(S), 0);
    check("single_e1_gnt0", 32'(GNT0), 0);
    step;
    check("single_e2_gnt0", 32'(GNT0), 1);
    check("single_e2_yv", 32'(YV), 0);
    step;
    check("single_e3_gnt0", 32'(GNT0), 0);
    check("single_e3_yv", 32'(YV), 1);
    check("single_e3_y", 32'(Y), 32'(xf(8'h5A)));
    REQ0 = 1'b0; LAST0 = 1'b0; D0 = 8'h00;
    step;
    check("single_e4_yv", 32'(YV), 0);
    check("single_e4_yhold", 32'(Y), 32'(xf(8'h5A)));
    check("single_e4_gnt", 32'({GNT1, GNT0}), 0);
    // Pointer now favours requester 1
    REQ0 = 1'b1; REQ1 = 1'b1;
    step;
    check("rr_s", 32'(S), 1);

    // Contention, MAXBURST = 4, no LAST
    do_reset;
    REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'h11; D1 = 8'h22;
    for (int e = 1; e <= 12; e++) begin
      logic eg0, eg1, es, eyv;
      step;
      eg0 = (e >= 2 && e <= 5) || e == 12;
      eg1 = (e >= 7 && e <= 10);
      es  = (e >= 6 && e <= 10);
      eyv = (e >= 3 && e <= 6) || (e >= 8 && e <= 11);
      check($sformatf("cont_e%0d_gnt0", e), 32'(GNT0), 32'(eg0));
      check($sformatf("cont_e%0d_gnt1", e), 32'(GNT1), 32'(eg1));
      check($sformatf("cont_e%0d_s", e), 32'(S), 32'(es));
      check($sformatf("cont_e%0d_yv", e), 32'(YV), 32'(eyv));
      if (eyv) check($sformatf("cont_e%0d_y", e), 32'(Y), 32'(xf(e <= 6 ? 8'h11 : 8'h22)));
    end

    // Early drop by requester 1 on its 2nd granted cycle
    do_reset;
    REQ1 = 1'b1; D1 = 8'h3C;
    step;
    check("drop_e1_s", 32'(S), 1);
    step;
    check("drop_e2_gnt1", 32'(GNT1), 1);
    step;
    check("drop_e3_yv", 32'(YV), 1);
    check("drop_e3_y", 32'(Y), 32'(xf(8'h3C)));
    check("drop_e3_gnt1", 32'(GNT1), 1);
    REQ1 = 1'b0;
    step;
    check("drop_e4_gnt1", 32'(GNT1), 0);
    check("drop_e4_yv", 32'(YV), 0);
    step;
    check("drop_e5_gnt", 32'({GNT1, GNT0}), 0);
    check("drop_e5_yv", 32'(YV), 0);

    // Reset on 3rd granted beat
    do_reset;
    REQ0 = 1'b1; D0 = 8'h77;
    step; step; step; step;
    check("mid_e4_yv", 32'(YV), 1);
    check("mid_e4_gnt0", 32'(GNT0), 1);
    R = 1'b0;
    step;
    check("mid_rst_gnt", 32'({GNT1, GNT0}), 0);
    check("mid_rst_s", 32'(S), 0);
    check("mid_rst_y", 32'(Y), 0);
    check("mid_rst_yv", 32'(YV), 0);
    R = 1'b1; REQ0 = 1'b0;
    step;
    check("mid_post_yv", 32'(YV), 0);
    check("mid_post_gnt", 32'({GNT1, GNT0}), 0);

    @(posedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
